// File: rtl/inst_fetch_ctrl_if.sv
// Instruction-bus interface for inst_fetch_ctrl: SRAM-like request/address/data handshake.
// The master issues a request and holds the address until it is accepted. The slave then
// returns exactly one data word.
`timescale 1ns/1ps
interface inst_fetch_ctrl_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    modport master (
        output inst_req,
        output inst_addr,
        input  inst_addr_ok,
        input  inst_data_ok,
        input  inst_rdata
    );

    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_addr_ok,
        output inst_data_ok,
        output inst_rdata
    );
endinterface

// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: PC generator and single-outstanding instruction-bus master.
// Each returned word is delivered as a one-cycle valid pulse.
// Branch redirects take effect after the delay slot completes.
// An exception flush redirects immediately and discards any response still in flight.
// Optional feature macro: IF_ADDR_CHECK_EN.
//  - When defined, a misaligned pc raises a fetch address exception and no request is issued.
//  - When undefined, the low two address bits are forced to zero.
`timescale 1ns/1ps
module inst_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            stall,
    input  logic                  flush,
    input  logic [31:0]           new_pc,
    input  logic                  branch_flag,
    input  logic [31:0]           branch_target,
    input  logic                  next_pc_valid,
    inst_fetch_ctrl_if.master     bus,
    output logic                  valid,
    output logic [31:0]           if_pc,
    output logic [31:0]           if_inst,
    output logic [31:0]           pc_excepttype_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT   = 2'd2,
        CANCEL = 2'd3
    } state_t;

    state_t      state_r,    state_s;
    logic [31:0] pc_r,       pc_s;
    logic [31:0] addr_r,     addr_s;
    logic        req_r,      req_s;
    logic        cancel_r,   cancel_s;    // flush seen during the address phase
    logic [31:0] flush_pc_r, flush_pc_s;
    logic        br_pend_r,  br_pend_s;
    logic [31:0] br_tgt_r,   br_tgt_s;
    logic        valid_r,    valid_s;
    logic [31:0] if_pc_r,    if_pc_s;
    logic [31:0] if_inst_r,  if_inst_s;
    logic [31:0] exc_r,      exc_s;
    logic        launch_ok_s;

    // Only stall[0] gates fetching; the upper stall bits belong to later stages.
    logic        unused_stall_s;
    assign unused_stall_s = ^stall[5:1];

    assign launch_ok_s = next_pc_valid && !stall[0];

    // Next-state and datapath update for the fetch FSM.
    always_comb begin
        state_s    = state_r;
        pc_s       = pc_r;
        addr_s     = addr_r;
        req_s      = req_r;
        cancel_s   = cancel_r;
        flush_pc_s = flush_pc_r;
        br_pend_s  = br_pend_r;
        br_tgt_s   = br_tgt_r;
        valid_s    = 1'b0;
        if_pc_s    = if_pc_r;
        if_inst_s  = if_inst_r;
        exc_s      = exc_r;

        // A flush wins over a branch in the same cycle and kills any pending branch.
        if (flush) begin
            br_pend_s  = 1'b0;
            flush_pc_s = new_pc;
        end else if (branch_flag) begin
            br_pend_s  = 1'b1;
            br_tgt_s   = branch_target;
        end else begin
            br_pend_s  = br_pend_r;
        end

        case (state_r)
            IDLE: begin
                req_s = 1'b0;
                if (flush) begin
                    pc_s = new_pc;
                end else if (launch_ok_s) begin
`ifdef IF_ADDR_CHECK_EN
                    if (pc_r[1:0] != 2'b00) begin
                        // Misaligned fetch: report AdEL and wait for the flush to redirect.
                        valid_s   = 1'b1;
                        if_pc_s   = pc_r;
                        if_inst_s = 32'h0000_0000;
                        exc_s     = 32'h0000_0010;
                    end else begin
                        state_s  = REQ;
                        req_s    = 1'b1;
                        addr_s   = pc_r;
                        cancel_s = 1'b0;
                    end
`else
                    state_s  = REQ;
                    req_s    = 1'b1;
                    addr_s   = {pc_r[31:2], 2'b00};
                    cancel_s = 1'b0;
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            REQ: begin
                // The request cannot be withdrawn, so a flush only marks it for cancellation.
                if (flush) begin
                    cancel_s = 1'b1;
                end else begin
                    cancel_s = cancel_r;
                end
                if (bus.inst_addr_ok) begin
                    req_s    = 1'b0;
                    cancel_s = 1'b0;
                    state_s  = (cancel_r || flush) ? CANCEL : WAIT;
                end else begin
                    req_s    = 1'b1;
                end
            end
            WAIT: begin
                if (bus.inst_data_ok) begin
                    state_s = IDLE;
                    if (flush) begin
                        pc_s = new_pc;
                    end else begin
                        valid_s   = 1'b1;
                        if_pc_s   = pc_r;
                        if_inst_s = bus.inst_rdata;
                        exc_s     = 32'h0000_0000;
                        // This completion is the delay slot of any latched branch.
                        pc_s      = br_pend_s ? br_tgt_s : (pc_r + 32'd4);
                        br_pend_s = 1'b0;
                    end
                end else if (flush) begin
                    state_s = CANCEL;
                end else begin
                    state_s = WAIT;
                end
            end
            CANCEL: begin
                if (bus.inst_data_ok) begin
                    pc_s    = flush_pc_s;
                    state_s = IDLE;
                end else begin
                    state_s = CANCEL;
                end
            end
            default: begin
                state_s = IDLE;
                req_s   = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            pc_r       <= RESET_PC;
            addr_r     <= 32'h0000_0000;
            req_r      <= 1'b0;
            cancel_r   <= 1'b0;
            flush_pc_r <= 32'h0000_0000;
            br_pend_r  <= 1'b0;
            br_tgt_r   <= 32'h0000_0000;
            valid_r    <= 1'b0;
            if_pc_r    <= 32'h0000_0000;
            if_inst_r  <= 32'h0000_0000;
            exc_r      <= 32'h0000_0000;
        end else begin
            state_r    <= state_s;
            pc_r       <= pc_s;
            addr_r     <= addr_s;
            req_r      <= req_s;
            cancel_r   <= cancel_s;
            flush_pc_r <= flush_pc_s;
            br_pend_r  <= br_pend_s;
            br_tgt_r   <= br_tgt_s;
            valid_r    <= valid_s;
            if_pc_r    <= if_pc_s;
            if_inst_r  <= if_inst_s;
            exc_r      <= exc_s;
        end
    end

    assign bus.inst_req    = req_r;
    assign bus.inst_addr   = addr_r;
    assign valid           = valid_r;
    assign if_pc           = if_pc_r;
    assign if_inst         = if_inst_r;
    assign pc_excepttype_o = exc_r;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed self-checking bench for inst_fetch_ctrl; the bench plays the instruction bus slave.
`timescale 1ns/1ps
module tb_inst_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        next_pc_valid;
    logic        valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic [31:0] pc_excepttype_o;

    int n_pass  = 0;
    int n_total = 0;

    logic        got;
    logic [31:0] addr;
    logic        v;
    logic [31:0] opc;
    logic [31:0] oinst;

    inst_fetch_ctrl_if bus ();

    inst_fetch_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .flush           (flush),
        .new_pc          (new_pc),
        .branch_flag     (branch_flag),
        .branch_target   (branch_target),
        .next_pc_valid   (next_pc_valid),
        .bus             (bus),
        .valid           (valid),
        .if_pc           (if_pc),
        .if_inst         (if_inst),
        .pc_excepttype_o (pc_excepttype_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for inst_req; returns whether it was seen and the address.
    task automatic wait_req(output logic g, output logic [31:0] a);
        g = 1'b0;
        a = 32'h0;
        for (int i = 0; i < 20; i++) begin
            if (!g && bus.inst_req === 1'b1) begin
                g = 1'b1;
                a = bus.inst_addr;
            end
            if (!g) tick();
        end
    endtask

    // Accept the address, return one word a cycle later, and sample the delivery.
    task automatic complete(input logic [31:0] rdata, output logic vo,
                            output logic [31:0] po, output logic [31:0] io);
        bus.inst_addr_ok = 1'b1;
        tick();
        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata   = rdata;
        tick();
        bus.inst_data_ok = 1'b0;
        vo = valid;
        po = if_pc;
        io = if_inst;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 6'd0; flush = 1'b0; new_pc = 32'h0;
        branch_flag = 1'b0; branch_target = 32'h0; next_pc_valid = 1'b0;
        bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b0; bus.inst_rdata = 32'h0;
        tick(); tick();
        n_total++; if (bus.inst_req !== 1'b0) $display("FAIL reset_req: got %b want 0", bus.inst_req); else n_pass++;
        n_total++; if (valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid); else n_pass++;
        n_total++; if (if_pc !== 32'h0) $display("FAIL reset_if_pc: got %h want 0", if_pc); else n_pass++;
        n_total++; if (if_inst !== 32'h0) $display("FAIL reset_if_inst: got %h want 0", if_inst); else n_pass++;
        n_total++; if (pc_excepttype_o !== 32'h0) $display("FAIL reset_exc: got %h want 0", pc_excepttype_o); else n_pass++;
    endtask

    task automatic test_first_fetch();
        rst = 1'b0; next_pc_valid = 1'b1;
        tick();
        n_total++; if (bus.inst_req !== 1'b1) $display("FAIL first_req: got %b want 1", bus.inst_req); else n_pass++;
        n_total++; if (bus.inst_addr !== 32'hBFC00000) $display("FAIL first_addr: got %h want bfc00000", bus.inst_addr); else n_pass++;
        complete(32'h24010001, v, opc, oinst);
        n_total++; if (v !== 1'b1) $display("FAIL first_valid: got %b want 1", v); else n_pass++;
        n_total++; if (opc !== 32'hBFC00000) $display("FAIL first_if_pc: got %h want bfc00000", opc); else n_pass++;
        n_total++; if (oinst !== 32'h24010001) $display("FAIL first_if_inst: got %h want 24010001", oinst); else n_pass++;
        n_total++; if (pc_excepttype_o !== 32'h0) $display("FAIL first_exc: got %h want 0", pc_excepttype_o); else n_pass++;
        tick();
        n_total++; if (valid !== 1'b0) $display("FAIL valid_pulse: got %b want 0", valid); else n_pass++;
        n_total++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'hBFC00004)
            $display("FAIL second_addr: got req %b addr %h want 1 bfc00004", bus.inst_req, bus.inst_addr); else n_pass++;
        complete(32'h00000000, v, opc, oinst);
        n_total++; if (v !== 1'b1 || opc !== 32'hBFC00004)
            $display("FAIL second_deliver: got %b %h want 1 bfc00004", v, opc); else n_pass++;
    endtask

    task automatic test_stall();
        stall = 6'b000001;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++; if (bus.inst_req !== 1'b0) $display("FAIL stall_req%0d: got %b want 0", i, bus.inst_req); else n_pass++;
        end
        stall = 6'd0;
        wait_req(got, addr);
        n_total++; if (got !== 1'b1 || addr !== 32'hBFC00008)
            $display("FAIL stall_release: got req %b addr %h want 1 bfc00008", got, addr); else n_pass++;
    endtask

    task automatic test_branch();
        branch_flag = 1'b1; branch_target = 32'h80001000;
        tick();
        branch_flag = 1'b0;
        complete(32'h00000021, v, opc, oinst);
        n_total++; if (v !== 1'b1 || opc !== 32'hBFC00008 || oinst !== 32'h00000021)
            $display("FAIL branch_slot: got %b %h %h want 1 bfc00008 00000021", v, opc, oinst); else n_pass++;
        wait_req(got, addr);
        n_total++; if (got !== 1'b1 || addr !== 32'h80001000)
            $display("FAIL branch_target: got %b %h want 1 80001000", got, addr); else n_pass++;
    endtask

    task automatic test_flush_wait();
        bus.inst_addr_ok = 1'b1; tick(); bus.inst_addr_ok = 1'b0;
        branch_flag = 1'b1; branch_target = 32'h90000000; tick(); branch_flag = 1'b0;
        flush = 1'b1; new_pc = 32'hBFC00380; tick(); flush = 1'b0;
        bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'hDEADBEEF; tick(); bus.inst_data_ok = 1'b0;
        n_total++; if (valid !== 1'b0) $display("FAIL flush_drop: got valid %b want 0", valid); else n_pass++;
        n_total++; if (if_pc !== 32'hBFC00008) $display("FAIL if_pc_hold: got %h want bfc00008", if_pc); else n_pass++;
        wait_req(got, addr);
        n_total++; if (got !== 1'b1 || addr !== 32'hBFC00380)
            $display("FAIL flush_target: got %b %h want 1 bfc00380", got, addr); else n_pass++;
        complete(32'h11111111, v, opc, oinst);
        n_total++; if (v !== 1'b1 || opc !== 32'hBFC00380)
            $display("FAIL flush_deliver: got %b %h want 1 bfc00380", v, opc); else n_pass++;
        wait_req(got, addr);
        n_total++; if (got !== 1'b1 || addr !== 32'hBFC00384)
            $display("FAIL flush_branch_lost: got %b %h want 1 bfc00384", got, addr); else n_pass++;
    endtask

    task automatic test_flush_vs_branch();
        flush = 1'b1; new_pc = 32'hBFC00400; branch_flag = 1'b1; branch_target = 32'h80002000;
        tick();
        flush = 1'b0; branch_flag = 1'b0;
        bus.inst_addr_ok = 1'b1; tick(); bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'h22222222; tick(); bus.inst_data_ok = 1'b0;
        n_total++; if (valid !== 1'b0) $display("FAIL req_flush_drop: got %b want 0", valid); else n_pass++;
        wait_req(got, addr);
        n_total++; if (got !== 1'b1 || addr !== 32'hBFC00400)
            $display("FAIL flush_wins: got %b %h want 1 bfc00400", got, addr); else n_pass++;
        complete(32'h33333333, v, opc, oinst);
        wait_req(got, addr);
        n_total++; if (got !== 1'b1 || addr !== 32'hBFC00404)
            $display("FAIL flush_wins_next: got %b %h want 1 bfc00404", got, addr); else n_pass++;
    endtask

    task automatic test_flush_with_data_ok();
        bus.inst_addr_ok = 1'b1; tick(); bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'h44444444; flush = 1'b1; new_pc = 32'h80000000;
        tick();
        bus.inst_data_ok = 1'b0; flush = 1'b0;
        n_total++; if (valid !== 1'b0) $display("FAIL same_cycle_drop: got %b want 0", valid); else n_pass++;
        wait_req(got, addr);
        n_total++; if (got !== 1'b1 || addr !== 32'h80000000)
            $display("FAIL same_cycle_target: got %b %h want 1 80000000", got, addr); else n_pass++;
    endtask

    task automatic test_double_flush();
        bus.inst_addr_ok = 1'b1; tick(); bus.inst_addr_ok = 1'b0;
        flush = 1'b1; new_pc = 32'h80000040; tick();
        new_pc = 32'h80000100; tick(); flush = 1'b0;
        bus.inst_data_ok = 1'b1; tick(); bus.inst_data_ok = 1'b0;
        n_total++; if (valid !== 1'b0) $display("FAIL cancel_drop: got %b want 0", valid); else n_pass++;
        wait_req(got, addr);
        n_total++; if (got !== 1'b1 || addr !== 32'h80000100)
            $display("FAIL second_flush: got %b %h want 1 80000100", got, addr); else n_pass++;
    endtask

    task automatic test_wrap();
        complete(32'h55555555, v, opc, oinst);
        next_pc_valid = 1'b0; flush = 1'b1; new_pc = 32'hFFFFFFFC;
        tick();
        flush = 1'b0;
        n_total++; if (bus.inst_req !== 1'b0) $display("FAIL idle_flush_req: got %b want 0", bus.inst_req); else n_pass++;
        next_pc_valid = 1'b1;
        wait_req(got, addr);
        n_total++; if (got !== 1'b1 || addr !== 32'hFFFFFFFC)
            $display("FAIL idle_flush_target: got %b %h want 1 fffffffc", got, addr); else n_pass++;
        complete(32'h66666666, v, opc, oinst);
        wait_req(got, addr);
        n_total++; if (got !== 1'b1 || addr !== 32'h00000000)
            $display("FAIL pc_wrap: got %b %h want 1 00000000", got, addr); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bus.inst_addr_ok = 1'b1; tick(); bus.inst_addr_ok = 1'b0;
        rst = 1'b1; next_pc_valid = 1'b0; tick(); rst = 1'b0;
        n_total++; if (bus.inst_req !== 1'b0) $display("FAIL mid_rst_req: got %b want 0", bus.inst_req); else n_pass++;
        bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'h77777777; tick(); bus.inst_data_ok = 1'b0;
        n_total++; if (valid !== 1'b0) $display("FAIL stale_data_ok: got %b want 0", valid); else n_pass++;
        next_pc_valid = 1'b1;
        wait_req(got, addr);
        n_total++; if (got !== 1'b1 || addr !== 32'hBFC00000)
            $display("FAIL mid_rst_pc: got %b %h want 1 bfc00000", got, addr); else n_pass++;
        complete(32'h88888888, v, opc, oinst);
    endtask

    task automatic test_addr_check();
        next_pc_valid = 1'b0; flush = 1'b1; new_pc = 32'h80000002;
        tick();
        flush = 1'b0; next_pc_valid = 1'b1;
        tick();
`ifdef IF_ADDR_CHECK_EN
        n_total++; if (bus.inst_req !== 1'b0) $display("FAIL adel_req: got %b want 0", bus.inst_req); else n_pass++;
        n_total++; if (valid !== 1'b1 || if_pc !== 32'h80000002 || if_inst !== 32'h0)
            $display("FAIL adel_deliver: got %b %h %h want 1 80000002 0", valid, if_pc, if_inst); else n_pass++;
        n_total++; if (pc_excepttype_o !== 32'h10) $display("FAIL adel_exc: got %h want 10", pc_excepttype_o); else n_pass++;
        next_pc_valid = 1'b0;
        tick();
        n_total++; if (bus.inst_req !== 1'b0) $display("FAIL adel_no_req: got %b want 0", bus.inst_req); else n_pass++;
`else
        n_total++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'h80000000)
            $display("FAIL align_addr: got %b %h want 1 80000000", bus.inst_req, bus.inst_addr); else n_pass++;
        complete(32'h99999999, v, opc, oinst);
        n_total++; if (v !== 1'b1 || pc_excepttype_o !== 32'h0)
            $display("FAIL align_exc: got %b %h want 1 0", v, pc_excepttype_o); else n_pass++;
        next_pc_valid = 1'b0;
        tick();
`endif
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_stall();
        test_branch();
        test_flush_wait();
        test_flush_vs_branch();
        test_flush_with_data_ok();
        test_double_flush();
        test_wrap();
        test_reset_mid();
        test_addr_check();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
